// File: rtl/input_debounce.sv
// Button/joystick pin conditioner: per-channel sync + stability-counter debounce
// with press/release pulses, opposite-direction lockout and an active-low core bus.

module input_debounce_lane #(
  parameter int STABLE_CYCLES = 240000,
  parameter int CNT_BITS      = 18,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic pin_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulse_d_o
);
  localparam logic                RELEASED = (ACTIVE_LOW != 0);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(STABLE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                s;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                state_q, state_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // s is normalised so 1 always means pressed
  assign s = sync2_q ^ RELEASED;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      state_d = s;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign state_o   = state_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pulse_d_o = rise_d | fall_d;
endmodule

module input_debounce #(
  parameter int pCHANNELS      = 8,
  parameter int pSTABLE_CYCLES = 240000,
  parameter int pCNT_BITS      = 18,
  parameter int pACTIVE_LOW    = 1,
  parameter int pLOCKOUT       = 1
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [pCHANNELS-1:0] iPINS,
  output logic [pCHANNELS-1:0] oSTATE,
  output logic [pCHANNELS-1:0] oRISE,
  output logic [pCHANNELS-1:0] oFALL,
  output logic                 oCHANGED,
  output logic [pCHANNELS-1:0] oCORE_N
);
  logic [pCHANNELS-1:0] pulse_d;
  logic [pCHANNELS-1:0] masked;
  logic                 changed_q;
  logic [pCHANNELS-1:0] core_n_q;

  for (genvar i = 0; i < pCHANNELS; i++) begin : g_lane
    input_debounce_lane #(
      .STABLE_CYCLES(pSTABLE_CYCLES),
      .CNT_BITS     (pCNT_BITS),
      .ACTIVE_LOW   (pACTIVE_LOW)
    ) u_lane (
      .iCLK     (iCLK),
      .iRESET   (iRESET),
      .pin_i    (iPINS[i]),
      .state_o  (oSTATE[i]),
      .rise_o   (oRISE[i]),
      .fall_o   (oFALL[i]),
      .pulse_d_o(pulse_d[i])
    );
  end

  if (pLOCKOUT != 0 && pCHANNELS >= 4) begin : g_lock
    // owner per pair: 2'b01 = lower channel, 2'b10 = upper channel, 2'b00 = none
    logic [1:0] own_q [2];
    logic [1:0] own_d [2];

    // owner_d folds in this cycle's rise so the newest press wins immediately
    always_comb begin
      masked = oSTATE;
      for (int p = 0; p < 2; p++) begin
        own_d[p] = own_q[p];
        if (oRISE[2*p +: 2] == 2'b01 || oRISE[2*p +: 2] == 2'b10)
          own_d[p] = oRISE[2*p +: 2];
        else if (oRISE[2*p +: 2] == 2'b11)
          own_d[p] = 2'b00;
        if (oSTATE[2*p +: 2] == 2'b11)
          masked[2*p +: 2] = own_d[p];
      end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
        for (int p = 0; p < 2; p++) own_q[p] <= 2'b00;
      end else begin
        for (int p = 0; p < 2; p++) own_q[p] <= own_d[p];
      end
    end
  end else begin : g_nolock
    assign masked = oSTATE;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      changed_q <= 1'b0;
      core_n_q  <= '1;
    end else begin
      changed_q <= |pulse_d;
      core_n_q  <= ~masked;
    end
  end

  assign oCHANGED = changed_q;
  assign oCORE_N  = core_n_q;
endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with an 8-cycle stability window, active-low pins.

module tb_input_debounce;
  logic       iCLK = 1'b0;
  logic       iRESET;
  logic [7:0] iPINS;
  logic [7:0] oSTATE, oRISE, oFALL, oCORE_N;
  logic       oCHANGED;

  int n_cmp = 0;
  int n_err = 0;

  input_debounce #(
    .pCHANNELS     (8),
    .pSTABLE_CYCLES(8),
    .pCNT_BITS     (4),
    .pACTIVE_LOW   (1),
    .pLOCKOUT      (1)
  ) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iPINS   (iPINS),
    .oSTATE  (oSTATE),
    .oRISE   (oRISE),
    .oFALL   (oFALL),
    .oCHANGED(oCHANGED),
    .oCORE_N (oCORE_N)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // advance n cycles; debounced state must hold and no pulses may appear
  task automatic quiet(input int n, input logic [7:0] st);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk("quiet_state", {24'd0, oSTATE}, {24'd0, st});
      chk("quiet_pulse", {15'd0, oRISE, oFALL, oCHANGED}, 32'd0);
    end
  endtask

  initial begin
    iRESET = 1'b1;
    iPINS  = 8'hFF;
    step(3);
    chk("rst_state", {24'd0, oSTATE}, 32'h00);
    chk("rst_core",  {24'd0, oCORE_N}, 32'hFF);
    chk("rst_pulse", {15'd0, oRISE, oFALL, oCHANGED}, 32'd0);

    iRESET = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle_state", {24'd0, oSTATE}, 32'h00);
      chk("idle_pulse", {15'd0, oRISE, oFALL, oCHANGED}, 32'd0);
      chk("idle_core",  {24'd0, oCORE_N}, 32'hFF);
    end

    // ch0 press: accepted 9 edges after first sample
    iPINS[0] = 1'b0;
    step(9);
    chk("p0_early",   {24'd0, oSTATE}, 32'h00);
    step(1);
    chk("p0_state",   {24'd0, oSTATE}, 32'h01);
    chk("p0_rise",    {24'd0, oRISE},  32'h01);
    chk("p0_fall",    {24'd0, oFALL},  32'h00);
    chk("p0_changed", {31'd0, oCHANGED}, 32'd1);
    chk("p0_core_lag",{24'd0, oCORE_N}, 32'hFF);
    step(1);
    chk("p0_rise_w",  {24'd0, oRISE},  32'h00);
    chk("p0_chg_w",   {31'd0, oCHANGED}, 32'd0);
    chk("p0_core",    {24'd0, oCORE_N}, 32'hFE);

    // ch1 bounce: 7 low, 1 high, 7 low, high -> rejected
    iPINS[1] = 1'b0; quiet(7, 8'h01);
    iPINS[1] = 1'b1; quiet(1, 8'h01);
    iPINS[1] = 1'b0; quiet(7, 8'h01);
    iPINS[1] = 1'b1; quiet(10, 8'h01);
    // held 8+ samples -> accepted; ch1 is newest, so it owns the pair
    iPINS[1] = 1'b0; quiet(9, 8'h01);
    step(1);
    chk("p1_state", {24'd0, oSTATE}, 32'h03);
    chk("p1_rise",  {24'd0, oRISE},  32'h02);
    step(1);
    chk("p1_core",  {24'd0, oCORE_N}, 32'hFD);

    iPINS[1:0] = 2'b11;
    step(10);
    chk("r01_state", {24'd0, oSTATE}, 32'h00);
    chk("r01_fall",  {24'd0, oFALL},  32'h03);
    chk("r01_rise",  {24'd0, oRISE},  32'h00);
    chk("r01_chg",   {31'd0, oCHANGED}, 32'd1);
    step(1);
    chk("r01_core",  {24'd0, oCORE_N}, 32'hFF);

    // left/right lockout: newest press wins, release hands back
    iPINS[2] = 1'b0;
    step(10);
    chk("p2_state", {24'd0, oSTATE}, 32'h04);
    chk("p2_rise",  {24'd0, oRISE},  32'h04);
    step(1);
    chk("p2_core",  {24'd0, oCORE_N}, 32'hFB);
    step(9);
    iPINS[3] = 1'b0;
    step(10);
    chk("p3_state", {24'd0, oSTATE}, 32'h0C);
    chk("p3_rise",  {24'd0, oRISE},  32'h08);
    chk("p3_lag",   {24'd0, oCORE_N}, 32'hFB);
    step(1);
    chk("p3_core",  {24'd0, oCORE_N}, 32'hF7);
    iPINS[3] = 1'b1;
    step(10);
    chk("r3_state", {24'd0, oSTATE}, 32'h04);
    chk("r3_fall",  {24'd0, oFALL},  32'h08);
    step(1);
    chk("r3_core",  {24'd0, oCORE_N}, 32'hFB);
    iPINS[2] = 1'b1;
    step(11);
    chk("r2_state", {24'd0, oSTATE}, 32'h00);
    chk("r2_core",  {24'd0, oCORE_N}, 32'hFF);

    // up/down pressed on the same cycle: both masked until one releases
    iPINS[1:0] = 2'b00;
    step(10);
    chk("b01_state", {24'd0, oSTATE}, 32'h03);
    chk("b01_rise",  {24'd0, oRISE},  32'h03);
    step(1);
    chk("b01_core",  {24'd0, oCORE_N}, 32'hFF);
    step(5);
    chk("b01_hold",  {24'd0, oCORE_N}, 32'hFF);
    iPINS[1] = 1'b1;
    step(9);
    chk("b1r_early", {24'd0, oSTATE}, 32'h03);
    chk("b1r_core0", {24'd0, oCORE_N}, 32'hFF);
    step(1);
    chk("b1r_state", {24'd0, oSTATE}, 32'h01);
    chk("b1r_fall",  {24'd0, oFALL},  32'h02);
    chk("b1r_lag",   {24'd0, oCORE_N}, 32'hFF);
    step(1);
    chk("b1r_core",  {24'd0, oCORE_N}, 32'hFE);

    // reset with ch4 mid-count (counter at 5)
    iPINS[4] = 1'b0;
    step(7);
    chk("m4_pre",    {24'd0, oSTATE}, 32'h01);
    #2 iRESET = 1'b1;
    #1;
    chk("ar_state",  {24'd0, oSTATE}, 32'h00);
    chk("ar_core",   {24'd0, oCORE_N}, 32'hFF);
    chk("ar_pulse",  {15'd0, oRISE, oFALL, oCHANGED}, 32'd0);
    step(2);
    iRESET = 1'b0;
    step(9);
    chk("pr_state",  {24'd0, oSTATE}, 32'h00);
    chk("pr_pulse",  {15'd0, oRISE, oFALL, oCHANGED}, 32'd0);
    chk("pr_core",   {24'd0, oCORE_N}, 32'hFF);
    step(1);
    chk("pr_acc",    {24'd0, oSTATE}, 32'h11);
    chk("pr_rise",   {24'd0, oRISE},  32'h11);
    step(1);
    chk("pr_core2",  {24'd0, oCORE_N}, 32'hEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
